// File: rtl/hs_unit_pkg.sv
// hs_unit shared package: pipeline register limits and stage mode encodings.
// Imported by hs_unit_pipe_stage and hs_unit_pipe_reg.
package hs_unit_pkg;

    localparam int unsigned HS_PIPE_MAX_STAGES = 16;

    localparam logic HS_PIPE_FWD  = 1'b0;
    localparam logic HS_PIPE_SKID = 1'b1;

endpackage

// File: rtl/hs_unit_pipe_stage.sv
// hs_unit_pipe_stage: one valid/ready register stage, forward or skid mode.
// Ports: clk, aresetn (async, active-low), flush (sync discard of valids),
//   in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data
//   (downstream), busy (stage holds at least one beat).
module hs_unit_pipe_stage
    import hs_unit_pkg::*;
#(
    parameter type      DATA_TYPE   = logic,
    parameter DATA_TYPE RESET_VALUE = '0,
    parameter logic     SKID        = HS_PIPE_FWD
) (
    input  logic     clk,
    input  logic     aresetn,
    input  logic     flush,
    input  logic     in_valid,
    output logic     in_ready,
    input  DATA_TYPE in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output DATA_TYPE out_data,
    output logic     busy
);

    if (SKID == HS_PIPE_SKID) begin : g_skid
        logic     v_q, v_d;
        logic     sv_q, sv_d;
        DATA_TYPE d_q, d_d;
        DATA_TYPE sd_q, sd_d;
        logic     in_fire;

        // in_ready depends only on sv_q, so no ready path crosses this stage.
        always_comb begin
            in_fire = in_valid && !sv_q;
            v_d     = v_q;
            sv_d    = sv_q;
            d_d     = d_q;
            sd_d    = sd_q;
            if (flush) begin
                v_d  = 1'b0;
                sv_d = 1'b0;
            end else if (out_ready) begin
                if (sv_q) begin
                    d_d  = sd_q;
                    v_d  = 1'b1;
                    sv_d = 1'b0;
                end else if (in_fire) begin
                    d_d = in_data;
                    v_d = 1'b1;
                end else begin
                    v_d = 1'b0;
                end
            end else if (in_fire) begin
                // Main entry stalled: park the new beat in the skid entry.
                if (v_q) begin
                    sd_d = in_data;
                    sv_d = 1'b1;
                end else begin
                    d_d = in_data;
                    v_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                v_q  <= 1'b0;
                sv_q <= 1'b0;
                d_q  <= RESET_VALUE;
                sd_q <= RESET_VALUE;
            end else begin
                v_q  <= v_d;
                sv_q <= sv_d;
                d_q  <= d_d;
                sd_q <= sd_d;
            end
        end

        assign in_ready  = !sv_q;
        assign out_valid = v_q;
        assign out_data  = d_q;
        assign busy      = v_q || sv_q;
    end else begin : g_fwd
        logic     v_q, v_d;
        DATA_TYPE d_q, d_d;
        logic     rdy;

        // Ready passes straight through so bubbles collapse.
        assign rdy = !v_q || out_ready;

        always_comb begin
            v_d = v_q;
            d_d = d_q;
            if (flush) begin
                v_d = 1'b0;
            end else if (in_valid && rdy) begin
                d_d = in_data;
                v_d = 1'b1;
            end else if (out_ready) begin
                v_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                v_q <= 1'b0;
                d_q <= RESET_VALUE;
            end else begin
                v_q <= v_d;
                d_q <= d_d;
            end
        end

        assign in_ready  = rdy;
        assign out_valid = v_q;
        assign out_data  = d_q;
        assign busy      = v_q;
    end

endmodule

// File: rtl/hs_unit_pipe_reg.sv
// hs_unit_pipe_reg: elastic pipeline of STAGES valid/ready register stages.
// Ports: clk, aresetn (async, active-low), flush (sync discard),
//   s_valid/s_ready/s_data (upstream), m_valid/m_ready/m_data (downstream),
//   busy (any beat in flight). flush gates s_ready and m_valid low.
module hs_unit_pipe_reg
    import hs_unit_pkg::*;
#(
    parameter type         DATA_TYPE   = logic,
    parameter DATA_TYPE    RESET_VALUE = '0,
    parameter int unsigned STAGES      = 2,
    parameter logic        SKID        = HS_PIPE_FWD
) (
    input  logic     clk,
    input  logic     aresetn,
    input  logic     flush,
    input  logic     s_valid,
    output logic     s_ready,
    input  DATA_TYPE s_data,
    output logic     m_valid,
    input  logic     m_ready,
    output DATA_TYPE m_data,
    output logic     busy
);

    if (STAGES < 1 || STAGES > HS_PIPE_MAX_STAGES) begin : g_bad_stages
        $error("hs_unit_pipe_reg: STAGES must be 1..16");
    end

    logic [STAGES-1:0] stg_busy;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic     in_v, in_r, out_v, out_r;
        DATA_TYPE in_d, out_d;

        if (i == 0) begin : g_head
            assign in_v = s_valid;
            assign in_d = s_data;
        end else begin : g_link
            assign in_v = g_stage[i-1].out_v;
            assign in_d = g_stage[i-1].out_d;
        end

        if (i == STAGES - 1) begin : g_tail
            assign out_r = m_ready;
        end else begin : g_next
            assign out_r = g_stage[i+1].in_r;
        end

        hs_unit_pipe_stage #(
            .DATA_TYPE   (DATA_TYPE),
            .RESET_VALUE (RESET_VALUE),
            .SKID        (SKID)
        ) u_stage (
            .clk       (clk),
            .aresetn   (aresetn),
            .flush     (flush),
            .in_valid  (in_v),
            .in_ready  (in_r),
            .in_data   (in_d),
            .out_valid (out_v),
            .out_ready (out_r),
            .out_data  (out_d),
            .busy      (stg_busy[i])
        );
    end

    assign s_ready = g_stage[0].in_r && !flush;
    assign m_valid = g_stage[STAGES-1].out_v && !flush;
    assign m_data  = g_stage[STAGES-1].out_d;
    assign busy    = |stg_busy;

endmodule

// File: tb/tb_hs_unit_pipe_reg.sv
// Bench for hs_unit_pipe_reg: forward (3 stages) and skid (2 stages)
// instances driven side by side, checked against a queue scoreboard.
module tb_hs_unit_pipe_reg;

    logic       clk = 1'b0;
    logic       aresetn;
    logic       flush;
    logic       s_valid [2];
    logic       s_ready [2];
    logic [7:0] s_data  [2];
    logic       m_valid [2];
    logic       m_ready [2];
    logic [7:0] m_data  [2];
    logic       busy    [2];

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         nin  [2];
    int         nout [2];
    logic       stall_prev [2];

    localparam int NBEATS = 10000;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    hs_unit_pipe_reg #(
        .DATA_TYPE   (logic [7:0]),
        .RESET_VALUE (8'hA5),
        .STAGES      (3),
        .SKID        (1'b0)
    ) dut_fwd (
        .clk     (clk),
        .aresetn (aresetn),
        .flush   (flush),
        .s_valid (s_valid[0]),
        .s_ready (s_ready[0]),
        .s_data  (s_data[0]),
        .m_valid (m_valid[0]),
        .m_ready (m_ready[0]),
        .m_data  (m_data[0]),
        .busy    (busy[0])
    );

    hs_unit_pipe_reg #(
        .DATA_TYPE   (logic [7:0]),
        .RESET_VALUE (8'h5A),
        .STAGES      (2),
        .SKID        (1'b1)
    ) dut_skid (
        .clk     (clk),
        .aresetn (aresetn),
        .flush   (flush),
        .s_valid (s_valid[1]),
        .s_ready (s_ready[1]),
        .s_data  (s_data[1]),
        .m_valid (m_valid[1]),
        .m_ready (m_ready[1]),
        .m_data  (m_data[1]),
        .busy    (busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rv(input int k);
        return (k == 0) ? 8'hA5 : 8'h5A;
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic clear_sb();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            nin[k]        = 0;
            nout[k]       = 0;
            stall_prev[k] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 1'b0;
            s_data[k]  = 8'h00;
            m_ready[k] = 1'b0;
        end
    endtask

    // Evaluate the handshakes that the coming rising edge will perform.
    task automatic observe();
        for (int k = 0; k < 2; k++) begin
            if (m_valid[k]) begin
                chk("sb_nonempty", 32'(qsize(k) != 0), 1);
                if (qsize(k) != 0)
                    chk("m_data", m_data[k], (k == 0) ? q0[0] : q1[0]);
            end
            if (stall_prev[k] && !flush)
                chk("hold_valid", m_valid[k], 1);
            if (m_valid[k] && m_ready[k] && qsize(k) != 0) begin
                if (k == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                nout[k]++;
            end
            if (s_valid[k] && s_ready[k]) begin
                if (k == 0) q0.push_back(s_data[k]);
                else        q1.push_back(s_data[k]);
                nin[k]++;
            end
            stall_prev[k] = m_valid[k] && !m_ready[k] && !flush;
        end
    endtask

    task automatic tick();
        #1;
        observe();
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_m_valid"}, m_valid[k], 0);
            chk({tag, "_m_data"}, m_data[k], rv(k));
            chk({tag, "_s_ready"}, s_ready[k], 1);
            chk({tag, "_busy"}, busy[k], 0);
        end
    endtask

    // Starts and ends on a falling edge; pipe k must be empty on entry.
    task automatic latency(input int k, input int exp);
        int lat;
        s_valid[k] = 1'b1;
        s_data[k]  = 8'h01;
        m_ready[k] = 1'b1;
        #1;
        chk("lat_s_ready", s_ready[k], 1);
        @(posedge clk);
        #1;
        s_valid[k] = 1'b0;
        lat = 1;
        while (!m_valid[k] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, exp);
        chk("lat_data", m_data[k], 8'h01);
        @(posedge clk);
        @(negedge clk);
        chk("lat_drained", busy[k], 0);
        m_ready[k] = 1'b0;
    endtask

    task automatic backpressure(input int k, input int cap);
        int cnt;
        clear_sb();
        m_ready[k] = 1'b0;
        for (int i = 0; i < 3 * cap + 2; i++) begin
            s_valid[k] = 1'b1;
            s_data[k]  = 8'h40 + 8'(nin[k]);
            tick();
        end
        #1;
        chk("bp_accepted", nin[k], cap);
        chk("bp_s_ready", s_ready[k], 0);
        chk("bp_busy", busy[k], 1);
        s_valid[k] = 1'b0;
        m_ready[k] = 1'b1;
        cnt = 0;
        while (nout[k] < cap && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("bp_drained", nout[k], cap);
        chk("bp_sb_empty", qsize(k), 0);
        m_ready[k] = 1'b0;
    endtask

    initial begin
        #990000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, t_push, t_first, t_last;

        aresetn = 1'b0;
        flush   = 1'b0;
        idle_inputs();
        clear_sb();
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        #1;
        check_reset_state("rst");
        @(negedge clk);

        latency(0, 3);
        latency(1, 2);

        // Gapless stream into the forward pipe.
        clear_sb();
        m_ready[0] = 1'b1;
        t_push = -1;
        t_first = -1;
        t_last = -1;
        cnt = 0;
        while (nout[0] < 64 && cnt < 200) begin
            s_valid[0] = (nin[0] < 64);
            s_data[0]  = 8'(nin[0]);
            #1;
            observe();
            if (nin[0] == 1 && t_push < 0) t_push = cyc;
            if (nout[0] == 1 && t_first < 0) t_first = cyc;
            if (nout[0] == 64 && t_last < 0) t_last = cyc;
            @(negedge clk);
            cnt++;
        end
        s_valid[0] = 1'b0;
        chk("stream_count", nout[0], 64);
        chk("stream_fill", t_first - t_push, 3);
        chk("stream_gapless", t_last - t_first, 63);
        m_ready[0] = 1'b0;

        backpressure(0, 3);
        backpressure(1, 4);

        // Random valid/ready on both pipes.
        clear_sb();
        cnt = 0;
        while ((nout[0] < NBEATS || nout[1] < NBEATS) && cnt < 50000) begin
            for (int k = 0; k < 2; k++) begin
                s_valid[k] = (nin[k] < NBEATS) && ($urandom_range(1) == 1);
                s_data[k]  = 8'($urandom);
                m_ready[k] = ($urandom_range(1) == 1);
            end
            tick();
            cnt++;
        end
        idle_inputs();
        chk("rand_out_fwd", nout[0], NBEATS);
        chk("rand_out_skid", nout[1], NBEATS);
        chk("rand_sb_fwd", qsize(0), 0);
        chk("rand_sb_skid", qsize(1), 0);

        // Flush with two beats held in each pipe.
        clear_sb();
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 2; k++) begin
                s_valid[k] = (nin[k] < 2);
                s_data[k]  = 8'h70 + 8'(nin[k]);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            chk("fl_loaded", nin[k], 2);
            chk("fl_busy_before", busy[k], 1);
            s_valid[k] = 1'b1;
            s_data[k]  = 8'hEE;
            m_ready[k] = 1'b1;
        end
        flush = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("fl_s_ready", s_ready[k], 0);
            chk("fl_m_valid", m_valid[k], 0);
        end
        @(negedge clk);
        flush = 1'b0;
        for (int k = 0; k < 2; k++) s_valid[k] = 1'b0;
        clear_sb();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("fl_busy_after", busy[k], 0);
            chk("fl_m_valid_after", m_valid[k], 0);
            chk("fl_data_kept", m_data[k], 8'h70);
        end
        @(negedge clk);
        repeat (6) tick();
        chk("fl_no_out_fwd", nout[0], 0);
        chk("fl_no_out_skid", nout[1], 0);
        idle_inputs();

        // Asynchronous reset between edges with beats in flight.
        clear_sb();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 2; k++) begin
                s_valid[k] = 1'b1;
                s_data[k]  = 8'h90 + 8'(i);
            end
            tick();
        end
        @(posedge clk);
        #3;
        idle_inputs();
        aresetn = 1'b0;
        #1;
        check_reset_state("async_rst");
        clear_sb();
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        latency(0, 3);
        latency(1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hs_unit_pipe_reg.md
# hs_unit_pipe_reg

Parametrised elastic pipeline register: a chain of `STAGES` clock-enabled registers with a valid/ready handshake, generic data type and optional skid buffering per stage. It is the handshaked successor of the plain clock-enabled DFF. Use it wherever a datapath needs retiming across a back-pressured stream interface, for example between interconnect hops, before wide arithmetic, or at block boundaries. It gives full throughput without the ready path limiting timing.

## Interface
Parameters:
- `DATA_TYPE`, `logic`: payload type. Any packed type.
- `RESET_VALUE`, `'0`: data-register value after reset.
- `STAGES`, `2`: number of register stages, 1..16. Other values are an elaboration error.
- `SKID`, `1'b0`: stage mode. 0 = forward stage, where ready is combinational through the chain. 1 = skid stage, where `s_ready` is registered.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous discard of all in-flight data.
- `s_valid`  in  1  upstream data valid.
- `s_ready`  out  1  upstream may transfer.
- `s_data`  in  `DATA_TYPE`  upstream payload.
- `m_valid`  out  1  downstream data valid.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  `DATA_TYPE`  downstream payload.
- `busy`  out  1  OR of all stage valid bits (main and skid).

## Operation
- Transfer rule: a transfer occurs on an edge where valid && ready on that side.
- Stage contents:
  - Forward stage: one entry (`v`, `d`).
  - Skid stage: a main entry plus a skid entry (`sv`, `sd`).
- Forward stage:
  - `in_ready = !v || out_ready`.
  - On an input transfer, `d <= in_data` and `v <= 1`.
  - Else if `out_ready`, `v <= 0`.
  - Bubbles collapse.
- Skid stage:
  - `in_ready = !sv`, which is a registered signal.
  - Input transfer while `v && !out_ready`: the data goes to the skid entry and `sv <= 1`.
  - When `out_ready && sv`: main loads from skid and `sv <= 0`. A simultaneous input is impossible because `in_ready` is 0.
  - When `out_ready && !sv`: main loads from the input if there is an input transfer, otherwise `v <= 0`.
- Data registers load only on their own enable (accept). They are never cleared except by reset.
- AXI-stream rule: `m_data` and `m_valid` stay stable while `m_valid && !m_ready`. No beat is dropped or duplicated and order is preserved.
- `flush` has priority over all handshakes:
  - While `flush` = 1, `s_ready` = 0 and `m_valid` = 0 (gated combinationally), so no transfer occurs on either side.
  - At the edge, every `v`/`sv` clears. Data registers are unchanged.
- Reset mid-operation: all `v`/`sv` clear immediately (asynchronously) and all data registers take `RESET_VALUE`. In-flight beats are lost by design.

## Timing
- Reset values:
  - `m_valid` = 0, `busy` = 0, `m_data` = `RESET_VALUE`.
  - `s_ready` = 1 in both modes, unless `flush` = 1.
- Latency: `STAGES` cycles from the `s_*` transfer edge to `m_valid` = 1, when the chain is empty and not blocked.
- Throughput: 1 beat per cycle sustained while `m_ready` = 1, in both modes.
- Forward mode: a combinational path runs `m_ready` → `s_ready` through all stages.
- Skid mode: `s_ready` has no combinational input path, so it is flop-only apart from the `flush` gate.
- Capacity: `STAGES` beats in forward mode, `2*STAGES` beats in skid mode.
- After `m_ready` falls:
  - Forward: `s_ready` falls the same cycle once the chain is full.
  - Skid: `s_ready` falls one cycle after the last skid slot fills.
- `busy` is combinational from the valid registers. It is 0 exactly when the pipe is empty.

## Structure
- Shared package `hs_unit_pkg` holds:
  - `HS_PIPE_MAX_STAGES = 16`.
  - Mode constants `HS_PIPE_FWD = 1'b0`, `HS_PIPE_SKID = 1'b1`.
- Sub-module `hs_unit_pipe_stage`: one stage, with parameters `DATA_TYPE`, `RESET_VALUE`, `SKID`, and in/out valid/ready/data plus `flush`. The top level generates `STAGES` instances chained in order, ANDs the `flush` gating into `s_ready`/`m_valid`, and ORs the stage valids into `busy`.

## Test plan
- Reset, then `STAGES` = 3, `SKID` = 0, `RESET_VALUE` = 8'hA5. Check `m_valid` = 0, `m_data` = 8'hA5, `s_ready` = 1, `busy` = 0. Send 8'h01 → `m_valid` rises exactly 3 cycles later with `m_data` = 8'h01.
- Stream 8'h00..8'h3F with `m_ready` = 1 → one beat out per cycle, in order, no gaps after the 3-cycle fill.
- Back-pressure with `SKID` = 1, `STAGES` = 2: hold `m_ready` = 0 and drive `s_valid` = 1 → exactly 4 beats accepted, then `s_ready` = 0. `m_data` stays stable. Release → 4 beats emerge in order.
- Random `s_valid`/`m_ready` (50%), 10k beats, both modes → scoreboard matches, and no `m_data` change while `m_valid && !m_ready`.
- Pipe holds 2 beats, pulse `flush` for 1 cycle → `s_ready` = 0 and `m_valid` = 0 that cycle. Next cycle `busy` = 0 and no flushed beat appears.
- Deassert `aresetn` mid-stream between edges → outputs go to reset values immediately. After release, a fresh beat passes with the nominal latency.
